ctrl_fsm: RTL and testbench
===========================

Name: ctrl_fsm

Overview:
Multicycle control state machine for the 16-bit accumulator datapath. It sits directly upstream of the PC block and drives PCWrite, PCSrc, Branch and bneOrbeq, plus the instruction-register, memory and accumulator enables. It decodes the 4-bit opcode from the instruction register and sequences fetch, decode and execute. It also waits on a memory-ready handshake, with a watchdog on that wait.

Parameters:
OPW, 4, opcode width (instruction bits [15:12])
MEM_WAIT_MAX, 15, max cycles a memory state waits for mem_ready before timeout
WDW, 4, watchdog counter width; must satisfy 2^WDW > MEM_WAIT_MAX

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
opcode  input  OPW  IR[15:12], valid from DECODE onward
mem_ready  input  1  memory access completes this cycle
PCWrite  output  1  unconditional PC load
PCSrc  output  2  00 = PC+1 (InA), 01 = branch target (InB), 10 = jump target (InC)
Branch  output  1  conditional PC load; PC block qualifies it with Zero
bneOrbeq  output  1  1 = BEQ (take when Zero=1), 0 = BNE (take when Zero=0)
IRWrite  output  1  latch instruction
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IorD  output  1  0 = address from PC, 1 = address from IR[11:0]
AccWrite  output  1  accumulator load
AccSrc  output  2  00 = ALU, 01 = memory data, 10 = sign-extended IR[11:0]
ALUOp  output  2  00 = ADD, 01 = SUB, 10 = AND, 11 = OR
halted  output  1  in HALT state
illegal_op  output  1  sticky; undefined opcode decoded
mem_timeout  output  1  sticky; watchdog expired
state_dbg  output  4  current state encoding

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 LDA, 5 STA, 6 LDI, 7 BEQ, 8 BNE, 9 JMP, F HALT. Opcodes A-E are illegal.
- States and encodings: FETCH 0, DECODE 1, ALU 2, MEMRD 3, MEMWB 4, MEMWR 5, LDI 6, BR 7, JMP 8, HALT 9. Encodings 10-15 are unreachable and go to FETCH.
- Reset (low, async): state = FETCH; watchdog = 0; illegal_op = 0; mem_timeout = 0. All outputs take their FETCH values with mem_ready = 0, i.e. only MemRead = 1 and everything else 0.
- Outputs are a function of the current state, gated by mem_ready where noted. Any output not listed for a state is 0.
- FETCH: MemRead = 1, IorD = 0, PCSrc = 00.
  - mem_ready = 1: IRWrite = 1 and PCWrite = 1 in the same cycle; next state DECODE.
  - mem_ready = 0: stay in FETCH.
- DECODE: no strobes. Next state by opcode: 0-3 to ALU; 4 to MEMRD; 5 to MEMWR; 6 to LDI; 7 or 8 to BR; 9 to JMP; F to HALT.
  - Illegal opcode: set illegal_op; next state FETCH (executes as a NOP).
- ALU: AccWrite = 1, AccSrc = 00, ALUOp = opcode[1:0]; next state FETCH.
- MEMRD: MemRead = 1, IorD = 1. Waits on mem_ready; goes to MEMWB on mem_ready.
- MEMWB: AccWrite = 1, AccSrc = 01; next state FETCH.
- MEMWR: MemWrite = 1, IorD = 1. Waits on mem_ready; goes to FETCH on mem_ready.
- LDI: AccWrite = 1, AccSrc = 10; next state FETCH.
- BR: Branch = 1, PCSrc = 01, bneOrbeq = (opcode == 7); next state FETCH. Zero is not an input to this block.
- JMP: PCWrite = 1, PCSrc = 10; next state FETCH.
- HALT: halted = 1; all strobes 0; stays in HALT until reset.
- Latency: ALU, LDI, BR and JMP instructions take 3 cycles at zero wait. LDA takes 4 cycles; STA takes 3. Each wait cycle adds 1.
- Watchdog:
  - Counts cycles spent in FETCH, MEMRD or MEMWR with mem_ready = 0.
  - Clears to 0 on any state change.
  - If the count reaches MEM_WAIT_MAX while still waiting: set mem_timeout, next state HALT, suppress all strobes that cycle.
  - mem_ready = 1 on the same cycle the count reaches MEM_WAIT_MAX: completion wins, no timeout.
- Reset mid-operation: any state returns to FETCH immediately; a pending MemWrite is dropped combinationally.
- Sticky flags clear only on reset.

Decomposition:
- Shared package ctrl_pkg holds: opcode constants, state encodings, PCSrc, AccSrc and ALUOp encodings, and the default parameter values.
- One sub-module, ctrl_watchdog: the counter plus the expire compare. Inputs: CLK, reset, waiting, clear. Output: expired.
- State register, next-state logic and output decode stay in ctrl_fsm.

Test Plan:
- Reset: hold reset = 0 for 2 cycles, then release with mem_ready = 0 -> state_dbg = 0, MemRead = 1, PCWrite = 0, halted = 0, illegal_op = 0.
- ADD at zero wait: mem_ready = 1, opcode = 0 -> FETCH pulses PCWrite = 1, PCSrc = 00, IRWrite = 1; DECODE; ALU asserts AccWrite = 1, ALUOp = 00; back in FETCH on cycle 4.
- Branches: opcode = 7 -> in BR, Branch = 1, PCSrc = 01, bneOrbeq = 1, PCWrite = 0. Repeat with opcode = 8 -> bneOrbeq = 0.
- LDA with mem_ready held low 3 cycles in MEMRD -> MemRead = 1 and IorD = 1 for 4 cycles; MEMWB asserts AccWrite = 1, AccSrc = 01; instruction takes 7 cycles total.
- Timeout: STA with mem_ready held low -> MemWrite stays high for 15 cycles, then mem_timeout = 1, halted = 1, MemWrite = 0. Drive reset low -> flags clear, state_dbg = 0.
- Illegal opcode and HALT:
  - opcode = C -> illegal_op = 1, returns to FETCH, no AccWrite or PCWrite.
  - opcode = F -> halted stays 1 for 20 cycles with all strobes 0.
  - Drive reset low while in MEMWR -> MemWrite drops in the same cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle accumulator controller.
// Covers opcodes, state encodings, datapath select encodings and default parameter values.
package ctrl_pkg;

    localparam int OPW_DEF          = 4;
    localparam int MEM_WAIT_MAX_DEF = 15;
    localparam int WDW_DEF          = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_LDA  = 4'h4;
    localparam logic [3:0] OP_STA  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_BNE  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_ALU    = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_LDI    = 4'd6,
        S_BR     = 4'd7,
        S_JMP    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam logic [1:0] ACC_ALU = 2'b00;
    localparam logic [1:0] ACC_MEM = 2'b01;
    localparam logic [1:0] ACC_IMM = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'hA) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// Memory-wait watchdog: counts consecutive waiting cycles and flags expiry
// when the count has reached the limit while the wait is still pending.
module ctrl_watchdog
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF,
    parameter int WDW          = WDW_DEF
) (
    input  logic CLK,
    input  logic reset,
    input  logic waiting,
    input  logic clear,
    output logic expired
);

    localparam logic [WDW-1:0] LIMIT = WDW'(MEM_WAIT_MAX);

    logic [WDW-1:0] count_reg;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (waiting && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // A completing access drops waiting, so completion always beats expiry
    assign expired = waiting && (count_reg == LIMIT);

endmodule

// File: rtl/ctrl_fsm.sv
// Multicycle control FSM: fetch/decode/execute sequencing for the 16-bit
// accumulator datapath, with a mem_ready handshake guarded by a watchdog.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int OPW          = OPW_DEF,
    parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF,
    parameter int WDW          = WDW_DEF
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           PCWrite,
    output logic [1:0]     PCSrc,
    output logic           Branch,
    output logic           bneOrbeq,
    output logic           IRWrite,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IorD,
    output logic           AccWrite,
    output logic [1:0]     AccSrc,
    output logic [1:0]     ALUOp,
    output logic           halted,
    output logic           illegal_op,
    output logic           mem_timeout,
    output logic [3:0]     state_dbg
);

    state_t     state_reg, state_next;
    logic       illegal_reg, timeout_reg;
    logic       waiting, clear, expired;
    logic [3:0] op;

    assign op = 4'(opcode);

    assign waiting = ((state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                      (state_reg == S_MEMWR)) && !mem_ready;
    assign clear   = (state_next != state_reg);

    ctrl_watchdog #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX),
        .WDW         (WDW)
    ) u_watchdog (
        .CLK    (CLK),
        .reset  (reset),
        .waiting(waiting),
        .clear  (clear),
        .expired(expired)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_FETCH;
            illegal_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == S_DECODE) && is_illegal(op)) begin
                illegal_reg <= 1'b1;
            end
            if (expired) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        PCWrite    = 1'b0;
        PCSrc      = PC_INC;
        Branch     = 1'b0;
        bneOrbeq   = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IorD       = 1'b0;
        AccWrite   = 1'b0;
        AccSrc     = ACC_ALU;
        ALUOp      = ALU_ADD;
        halted     = 1'b0;

        case (state_reg)
            S_FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: state_next = S_ALU;
                    OP_LDA:                        state_next = S_MEMRD;
                    OP_STA:                        state_next = S_MEMWR;
                    OP_LDI:                        state_next = S_LDI;
                    OP_BEQ, OP_BNE:                state_next = S_BR;
                    OP_JMP:                        state_next = S_JMP;
                    OP_HALT:                       state_next = S_HALT;
                    default:                       state_next = S_FETCH;
                endcase
            end
            S_ALU: begin
                AccWrite = 1'b1;
                case (op)
                    OP_SUB:  ALUOp = ALU_SUB;
                    OP_AND:  ALUOp = ALU_AND;
                    OP_OR:   ALUOp = ALU_OR;
                    default: ALUOp = ALU_ADD;
                endcase
                state_next = S_FETCH;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                AccWrite   = 1'b1;
                AccSrc     = ACC_MEM;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_LDI: begin
                AccWrite   = 1'b1;
                AccSrc     = ACC_IMM;
                state_next = S_FETCH;
            end
            S_BR: begin
                Branch     = 1'b1;
                PCSrc      = PC_BR;
                bneOrbeq   = (op == OP_BEQ);
                state_next = S_FETCH;
            end
            S_JMP: begin
                PCWrite    = 1'b1;
                PCSrc      = PC_JMP;
                state_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase

        // Watchdog expiry: abandon the access quietly and park in HALT
        if (expired) begin
            state_next = S_HALT;
            PCWrite    = 1'b0;
            PCSrc      = PC_INC;
            IRWrite    = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            IorD       = 1'b0;
        end
    end

    assign illegal_op  = illegal_reg;
    assign mem_timeout = timeout_reg;
    assign state_dbg   = state_reg;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: table-driven vectors, hand-written
// multi-cycle corner sequences and a randomized instruction-level model.
module tb_ctrl_fsm;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, Branch, bneOrbeq, IRWrite, MemRead, MemWrite, IorD;
    logic       AccWrite, halted, illegal_op, mem_timeout;
    logic [1:0] PCSrc, AccSrc, ALUOp;
    logic [3:0] state_dbg;

    always #5 CLK = ~CLK;

    ctrl_fsm #(.OPW(4), .MEM_WAIT_MAX(15), .WDW(4)) dut (
        .CLK(CLK), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .Branch(Branch), .bneOrbeq(bneOrbeq),
        .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .AccWrite(AccWrite), .AccSrc(AccSrc), .ALUOp(ALUOp), .halted(halted),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state_dbg(state_dbg)
    );

    localparam int FE = 0, DE = 1, AL = 2, RD = 3, WB = 4, WR = 5, LI = 6, BR = 7, JM = 8, HL = 9;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       br;
        logic       bne;
        logic       irw;
        logic       mrd;
        logic       mwr;
        logic       iord;
        logic       aw;
        logic [1:0] accsrc;
        logic [1:0] aluop;
        logic       hlt;
        logic       ill;
        logic       tmo;
    } obs_t;

    typedef struct {
        logic [3:0] op;
        logic       mr;
        obs_t       e;
    } vec_t;

    typedef struct {
        logic mr;
        obs_t e;
    } step_t;

    int   checks = 0;
    int   errors = 0;
    logic m_ill = 1'b0;
    logic m_tmo = 1'b0;

    // Argument order: state, pcw, pcsrc, br, bne, irw, mrd, mwr, iord, aw, accsrc, aluop, hlt, ill, tmo
    function automatic obs_t mk(int st, bit pcw, bit [1:0] pcsrc, bit br, bit bne, bit irw,
                                bit mrd, bit mwr, bit iord, bit aw, bit [1:0] accsrc,
                                bit [1:0] aluop, bit hlt, bit ill, bit tmo);
        obs_t o;
        o.st = 4'(st); o.pcw = pcw; o.pcsrc = pcsrc; o.br = br; o.bne = bne; o.irw = irw;
        o.mrd = mrd; o.mwr = mwr; o.iord = iord; o.aw = aw; o.accsrc = accsrc;
        o.aluop = aluop; o.hlt = hlt; o.ill = ill; o.tmo = tmo;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(int'(state_dbg), PCWrite, PCSrc, Branch, bneOrbeq, IRWrite, MemRead, MemWrite,
                  IorD, AccWrite, AccSrc, ALUOp, halted, illegal_op, mem_timeout);
    endfunction

    task automatic check(input obs_t e, input string nm);
        obs_t a;
        a = sample();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, a, e);
        end
    endtask

    // Drive mem_ready for one cycle, check combinational outputs mid-cycle, advance.
    task automatic cyc(input logic mr, input obs_t e, input string nm);
        mem_ready = mr;
        #2;
        check(e, nm);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b1;
        m_ill = 1'b0;
        m_tmo = 1'b0;
    endtask

    // Instruction-level model: expected per-cycle behaviour built from the
    // instruction's phases (fetch, decode, execute) and its wait counts.
    task automatic run_instr(input logic [3:0] op, input int wf, input int wm);
        step_t q[$];
        obs_t  fe0, fe1, de, rdo, wro;
        fe0 = mk(FE, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, m_ill, m_tmo);
        fe1 = mk(FE, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, m_ill, m_tmo);
        de  = mk(DE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_ill, m_tmo);
        rdo = mk(RD, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, m_ill, m_tmo);
        wro = mk(WR, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, m_ill, m_tmo);
        for (int i = 0; i < wf; i++) q.push_back('{1'b0, fe0});
        q.push_back('{1'b1, fe1});
        q.push_back('{1'($urandom_range(0, 1)), de});
        if (op <= 4'h3) begin
            q.push_back('{1'($urandom_range(0, 1)),
                          mk(AL, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'(op), 0, m_ill, m_tmo)});
        end else if (op == 4'h4) begin
            for (int i = 0; i < wm; i++) q.push_back('{1'b0, rdo});
            q.push_back('{1'b1, rdo});
            q.push_back('{1'($urandom_range(0, 1)),
                          mk(WB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, m_ill, m_tmo)});
        end else if (op == 4'h5) begin
            for (int i = 0; i < wm; i++) q.push_back('{1'b0, wro});
            q.push_back('{1'b1, wro});
        end else if (op == 4'h6) begin
            q.push_back('{1'($urandom_range(0, 1)),
                          mk(LI, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, m_ill, m_tmo)});
        end else if (op == 4'h7 || op == 4'h8) begin
            q.push_back('{1'($urandom_range(0, 1)),
                          mk(BR, 0, 1, 1, (op == 4'h7), 0, 0, 0, 0, 0, 0, 0, 0, m_ill, m_tmo)});
        end else if (op == 4'h9) begin
            q.push_back('{1'($urandom_range(0, 1)),
                          mk(JM, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_ill, m_tmo)});
        end else begin
            m_ill = 1'b1;
        end
        opcode = op;
        $display("instr op=%h fetch_wait=%0d mem_wait=%0d cycles=%0d", op, wf, wm, q.size());
        foreach (q[i]) cyc(q[i].mr, q[i].e, $sformatf("rand_op%h_c%0d", op, i));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit got=expired want=finish");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t  tv[$];
        obs_t  f0, f1, dd, wr, hl;

        f0 = mk(FE, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        f1 = mk(FE, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        dd = mk(DE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wr = mk(WR, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);

        tv.push_back('{4'h0, 1'b1, f1});
        tv.push_back('{4'h0, 1'b0, dd});
        tv.push_back('{4'h0, 1'b1, mk(AL, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)});
        tv.push_back('{4'h7, 1'b0, f0});
        tv.push_back('{4'h7, 1'b1, f1});
        tv.push_back('{4'h7, 1'b1, dd});
        tv.push_back('{4'h7, 1'b0, mk(BR, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tv.push_back('{4'h8, 1'b1, f1});
        tv.push_back('{4'h8, 1'b0, dd});
        tv.push_back('{4'h8, 1'b1, mk(BR, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tv.push_back('{4'h1, 1'b1, f1});
        tv.push_back('{4'h1, 1'b0, dd});
        tv.push_back('{4'h1, 1'b0, mk(AL, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0)});
        tv.push_back('{4'h2, 1'b1, f1});
        tv.push_back('{4'h2, 1'b1, dd});
        tv.push_back('{4'h2, 1'b0, mk(AL, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0)});
        tv.push_back('{4'h3, 1'b1, f1});
        tv.push_back('{4'h3, 1'b0, dd});
        tv.push_back('{4'h3, 1'b1, mk(AL, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0)});
        tv.push_back('{4'h6, 1'b1, f1});
        tv.push_back('{4'h6, 1'b0, dd});
        tv.push_back('{4'h6, 1'b0, mk(LI, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0)});
        tv.push_back('{4'h9, 1'b1, f1});
        tv.push_back('{4'h9, 1'b1, dd});
        tv.push_back('{4'h9, 1'b0, mk(JM, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tv.push_back('{4'h0, 1'b0, f0});

        do_reset();
        $display("seq reset");
        cyc(1'b0, f0, "reset_state");

        for (int i = 0; i < tv.size(); i++) begin
            opcode = tv[i].op;
            $display("vec %0d op=%h mr=%0d want_state=%0d", i, tv[i].op, tv[i].mr, tv[i].e.st);
            cyc(tv[i].mr, tv[i].e, $sformatf("vec%0d", i));
        end

        // LDA with three wait cycles in MEMRD: 7 cycles until the next FETCH
        $display("seq lda_wait3");
        opcode = 4'h4;
        cyc(1'b1, f1, "lda_fetch");
        cyc(1'b0, dd, "lda_decode");
        for (int i = 0; i < 3; i++)
            cyc(1'b0, mk(RD, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), $sformatf("lda_wait%0d", i));
        cyc(1'b1, mk(RD, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), "lda_ready");
        cyc(1'b0, mk(WB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), "lda_wb");
        cyc(1'b0, f0, "lda_next_fetch");

        // STA completing on the very cycle the watchdog reaches its limit
        $display("seq sta_edge_complete");
        opcode = 4'h5;
        cyc(1'b1, f1, "sta_e_fetch");
        cyc(1'b0, dd, "sta_e_decode");
        for (int i = 0; i < 15; i++) cyc(1'b0, wr, $sformatf("sta_e_wait%0d", i));
        cyc(1'b1, wr, "sta_e_complete");
        cyc(1'b0, f0, "sta_e_no_timeout");

        // STA that never completes: 15 write cycles, one quiet cycle, then HALT
        $display("seq sta_timeout");
        cyc(1'b1, f1, "sta_t_fetch");
        cyc(1'b0, dd, "sta_t_decode");
        for (int i = 0; i < 15; i++) cyc(1'b0, wr, $sformatf("sta_t_wait%0d", i));
        cyc(1'b0, mk(WR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sta_t_expire");
        hl = mk(HL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc(1'b0, hl, "sta_t_halt");
        cyc(1'b1, hl, "sta_t_halt_hold");
        mem_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check(f0, "timeout_reset_clears");
        @(posedge CLK);
        #1;
        reset = 1'b1;

        // Illegal opcode executes as a NOP and raises the sticky flag
        $display("seq illegal_c");
        opcode = 4'hC;
        cyc(1'b1, f1, "ill_fetch");
        cyc(1'b0, dd, "ill_decode");
        cyc(1'b0, mk(FE, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0), "ill_back_fetch");

        // Reset asserted mid-cycle in MEMWR drops MemWrite without a clock edge
        $display("seq reset_in_memwr");
        opcode = 4'h5;
        cyc(1'b1, mk(FE, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0), "rw_fetch");
        cyc(1'b0, mk(DE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "rw_decode");
        mem_ready = 1'b0;
        #2;
        check(mk(WR, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0), "rw_before_reset");
        reset = 1'b0;
        #1;
        check(f0, "rw_memwrite_dropped");
        @(posedge CLK);
        #1;
        reset = 1'b1;

        // Watchdog also guards FETCH
        $display("seq fetch_timeout");
        for (int i = 0; i < 15; i++) cyc(1'b0, f0, $sformatf("fe_t_wait%0d", i));
        cyc(1'b0, mk(FE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fe_t_expire");
        cyc(1'b0, hl, "fe_t_halt");
        do_reset();

        for (int n = 0; n < 60; n++)
            run_instr(4'($urandom_range(0, 14)), $urandom_range(0, 3), $urandom_range(0, 4));

        // HALT holds for 20 cycles regardless of mem_ready
        $display("seq halt");
        run_instr(4'h0, 0, 0);
        opcode = 4'hF;
        cyc(1'b1, mk(FE, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, m_ill, 0), "halt_fetch");
        cyc(1'b0, mk(DE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_ill, 0), "halt_decode");
        for (int i = 0; i < 20; i++)
            cyc(1'($urandom_range(0, 1)), mk(HL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, m_ill, 0),
                $sformatf("halt_hold%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
